// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing one instruction over a shared-ALU/shared-memory datapath
module multicycle_control #(
    parameter int ALUOP_W  = 3,
    parameter int MEM_WAIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    input  logic               hold,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic [1:0]         PCSource,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegDst,
    output logic               RegWrite,
    output logic [3:0]         State,
    output logic               IllegalOp
);
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, RTEX = 4'd6, RTWB = 4'd7,
                           IMMEX = 4'd8, IMMWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
                           NONE = 4'd15;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_SLTI = 6'b001010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                           OP_J = 6'b000010;

    logic [3:0] r_state, r_cnt, w_next, w_dec, w_st;
    logic [5:0] r_op;
    logic [2:0] w_aluop;
    logic       w_wait, w_last;

    assign w_wait = r_state == FETCH || r_state == MEMRD || r_state == MEMWR;
    assign w_last = r_cnt == 4'(MEM_WAIT);
    assign w_st   = rst ? NONE : r_state;
    assign State  = rst ? 4'd0 : r_state;
    assign ALUOp  = ALUOP_W'(w_aluop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_cnt   <= 4'd0;
            r_op    <= 6'd0;
        end else if (!hold) begin
            r_state <= w_next;
            r_cnt   <= (w_wait && !w_last) ? r_cnt + 4'd1 : 4'd0;
            if (r_state == DECODE) r_op <= Opcode;
        end
    end

    always_comb begin
        case (Opcode)
            OP_R:                              w_dec = RTEX;
            OP_LW, OP_SW:                      w_dec = MEMADR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_dec = IMMEX;
            OP_BEQ, OP_BNE:                    w_dec = BRANCH;
            OP_J:                              w_dec = JUMP;
            default:                           w_dec = FETCH;
        endcase
    end

    always_comb begin
        case (r_state)
            FETCH:   w_next = w_last ? DECODE : FETCH;
            DECODE:  w_next = w_dec;
            MEMADR:  w_next = r_op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   w_next = w_last ? MEMWB : MEMRD;
            MEMWR:   w_next = w_last ? FETCH : MEMWR;
            RTEX:    w_next = RTWB;
            IMMEX:   w_next = IMMWB;
            default: w_next = FETCH;
        endcase
    end

    // reset selects an empty state so every output falls to zero
    always_comb begin
        PCWrite = 1'b0;
        PCWriteCond = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        IRWrite = 1'b0;
        PCSource = 2'b00;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b00;
        w_aluop = 3'b000;
        RegDst = 1'b0;
        RegWrite = 1'b0;
        IllegalOp = 1'b0;
        case (w_st)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_last;
                PCWrite = w_last;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                IllegalOp = w_dec == FETCH;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            RTEX: begin
                ALUSrcA = 1'b1;
                w_aluop = 3'b010;
            end
            RTWB: begin
                RegWrite = 1'b1;
                RegDst = 1'b1;
            end
            IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_aluop = r_op == OP_ANDI ? 3'b100 : r_op == OP_ORI ? 3'b101 :
                          r_op == OP_SLTI ? 3'b110 : 3'b011;
            end
            IMMWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA = 1'b1;
                w_aluop = 3'b001;
                PCSource = 2'b01;
                PCWriteCond = r_op == OP_BEQ;
                PCWriteCondNe = r_op == OP_BNE;
            end
            JUMP: begin
                PCWrite = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
        if (hold) begin
            PCWrite = 1'b0;
            PCWriteCond = 1'b0;
            PCWriteCondNe = 1'b0;
            IRWrite = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control at MEM_WAIT=0 and MEM_WAIT=2
module tb_multicycle_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, hold0 = 1'b0, rst2 = 1'b1, hold2 = 1'b0;
    logic [5:0] op0 = 6'd0, op2 = 6'd0;
    logic       pcw0, pcc0, pcn0, iord0, mr0, mw0, m2r0, irw0, sa0, rd0, rw0, ill0;
    logic       pcw2, pcc2, pcn2, iord2, mr2, mw2, m2r2, irw2, sa2, rd2, rw2, ill2;
    logic [1:0] pcs0, sb0, pcs2, sb2;
    logic [2:0] aop0;
    logic [3:0] aop2, st0, st2;

    multicycle_control #(.ALUOP_W(3), .MEM_WAIT(0)) u0 (
        .clk(clk), .rst(rst0), .Opcode(op0), .hold(hold0),
        .PCWrite(pcw0), .PCWriteCond(pcc0), .PCWriteCondNe(pcn0), .IorD(iord0),
        .MemRead(mr0), .MemWrite(mw0), .MemtoReg(m2r0), .IRWrite(irw0),
        .PCSource(pcs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0),
        .RegDst(rd0), .RegWrite(rw0), .State(st0), .IllegalOp(ill0)
    );

    multicycle_control #(.ALUOP_W(4), .MEM_WAIT(2)) u2 (
        .clk(clk), .rst(rst2), .Opcode(op2), .hold(hold2),
        .PCWrite(pcw2), .PCWriteCond(pcc2), .PCWriteCondNe(pcn2), .IorD(iord2),
        .MemRead(mr2), .MemWrite(mw2), .MemtoReg(m2r2), .IRWrite(irw2),
        .PCSource(pcs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUOp(aop2),
        .RegDst(rd2), .RegWrite(rw2), .State(st2), .IllegalOp(ill2)
    );

    logic [23:0] act0, act2;
    assign act0 = {st0, ill0, pcw0, pcc0, pcn0, iord0, mr0, mw0, m2r0, irw0, pcs0, sa0, sb0, 1'b0, aop0, rd0, rw0};
    assign act2 = {st2, ill2, pcw2, pcc2, pcn2, iord2, mr2, mw2, m2r2, irw2, pcs2, sa2, sb2, aop2, rd2, rw2};

    localparam logic [23:0] ILL = 24'h080000, PCW = 24'h040000, PCC = 24'h020000, PCN = 24'h010000,
                            IORD = 24'h008000, MRD = 24'h004000, MWR = 24'h002000, M2R = 24'h001000,
                            IRW = 24'h000800, SA = 24'h000100, RD = 24'h000002, RW = 24'h000001;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000,
                           ORI = 6'b001101, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010,
                           BAD = 6'b111111;

    function automatic logic [23:0] f(input logic [3:0] s, input logic [1:0] pcs, input logic [1:0] sb, input logic [2:0] aop);
        return {s, 9'd0, pcs, 1'b0, sb, 1'b0, aop, 2'b00};
    endfunction
    function automatic logic [23:0] fe(input logic last);
        return f(4'd0, 2'd0, 2'b01, 3'd0) | MRD | (last ? (IRW | PCW) : 24'd0);
    endfunction
    function automatic logic [23:0] de(input logic ill);
        return f(4'd1, 2'd0, 2'b11, 3'd0) | (ill ? ILL : 24'd0);
    endfunction
    function automatic logic [23:0] mw(input logic w);
        return f(4'd5, 2'd0, 2'd0, 3'd0) | IORD | (w ? MWR : 24'd0);
    endfunction
    function automatic logic [23:0] ix(input logic [2:0] a);
        return f(4'd8, 2'd0, 2'b10, a) | SA;
    endfunction
    function automatic logic [23:0] br(input logic c, input logic n);
        return f(4'd10, 2'b01, 2'b00, 3'b001) | SA | (c ? PCC : 24'd0) | (n ? PCN : 24'd0);
    endfunction

    typedef struct {
        bit          t;
        logic [23:0] e;
        string       nm;
    } item_t;
    item_t q[$];
    int n_tests = 0, n_fail = 0;

    task automatic s(input bit t, input logic r, input logic h, input logic [5:0] op, input logic [23:0] e, input string nm);
        item_t it;
        if (t) begin
            rst2 = r; hold2 = h; op2 = op;
        end else begin
            rst0 = r; hold0 = h; op0 = op;
        end
        it.t = t; it.e = e; it.nm = nm;
        q.push_back(it);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : mon
        item_t it;
        logic [23:0] a;
        if (q.size() > 0) begin
            it = q.pop_front();
            a = it.t ? act2 : act0;
            n_tests++;
            if (a !== it.e) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", it.nm, a, it.e);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        s(0, 1, 0, R,   24'd0, "w0_reset");
        s(0, 0, 0, R,   fe(1), "rt_fetch");
        s(0, 0, 0, R,   de(0), "rt_decode");
        s(0, 0, 0, R,   f(4'd6, 2'd0, 2'd0, 3'b010) | SA, "rt_exec");
        s(0, 0, 0, R,   f(4'd7, 2'd0, 2'd0, 3'd0) | RW | RD, "rt_wb");
        s(0, 0, 0, BEQ, fe(1), "beq_fetch");
        s(0, 0, 0, BEQ, de(0), "beq_decode");
        s(0, 0, 0, BNE, br(1, 0), "beq_branch_latched");
        s(0, 0, 0, BNE, fe(1), "bne_fetch");
        s(0, 0, 0, BNE, de(0), "bne_decode");
        s(0, 0, 0, BNE, br(0, 1), "bne_branch");
        s(0, 0, 0, J,   fe(1), "j_fetch");
        s(0, 0, 0, J,   de(0), "j_decode");
        s(0, 0, 0, J,   f(4'd11, 2'b10, 2'd0, 3'd0) | PCW, "j_jump");
        s(0, 0, 0, BAD, fe(1), "ill_fetch");
        s(0, 0, 0, BAD, de(1), "ill_decode");
        s(0, 0, 0, ORI, fe(1), "ori_fetch");
        s(0, 0, 0, ORI, de(0), "ori_decode");
        s(0, 0, 0, BAD, ix(3'b101), "ori_exec_latched");
        s(0, 0, 0, BAD, f(4'd9, 2'd0, 2'd0, 3'd0) | RW, "ori_wb");
        s(0, 0, 0, R,   fe(1), "rt2_fetch");
        s(0, 0, 0, R,   de(0), "rt2_decode");
        s(0, 1, 1, R,   24'd0, "rst_in_rtex_hold");
        s(0, 0, 0, ADDI, fe(1), "post_rst_fetch");
        s(0, 0, 0, ADDI, de(0), "addi_decode");
        s(0, 0, 0, ADDI, ix(3'b011), "addi_exec");
        s(0, 0, 0, ADDI, f(4'd9, 2'd0, 2'd0, 3'd0) | RW, "addi_wb");
        s(0, 0, 0, ADDI, fe(1), "addi_next_fetch");

        s(1, 1, 0, LW, 24'd0, "w2_reset");
        s(1, 0, 0, LW, fe(0), "lw_fetch0");
        s(1, 0, 0, LW, fe(0), "lw_fetch1");
        s(1, 0, 0, LW, fe(1), "lw_fetch2");
        s(1, 0, 0, LW, de(0), "lw_decode");
        s(1, 0, 0, SW, f(4'd2, 2'd0, 2'b10, 3'd0) | SA, "lw_memadr_latched");
        for (int i = 0; i < 3; i++) s(1, 0, 0, SW, f(4'd3, 2'd0, 2'd0, 3'd0) | MRD | IORD, "lw_memrd");
        s(1, 0, 0, SW, f(4'd4, 2'd0, 2'd0, 3'd0) | RW | M2R, "lw_memwb");
        s(1, 0, 0, SW, fe(0), "sw_fetch0");
        s(1, 0, 0, SW, fe(0), "sw_fetch1");
        s(1, 0, 0, SW, fe(1), "sw_fetch2");
        s(1, 0, 0, SW, de(0), "sw_decode");
        s(1, 0, 0, SW, f(4'd2, 2'd0, 2'b10, 3'd0) | SA, "sw_memadr");
        for (int i = 0; i < 3; i++) s(1, 0, 1, SW, mw(0), "sw_memwr_hold");
        for (int i = 0; i < 3; i++) s(1, 0, 0, SW, mw(1), "sw_memwr");
        s(1, 0, 0, SW, fe(0), "sw_done_fetch0");
        s(1, 0, 0, SW, fe(0), "fetch1");
        s(1, 0, 1, SW, fe(0), "fetch_last_hold");
        s(1, 0, 0, SW, fe(1), "fetch_last_release");
        s(1, 0, 0, BAD, de(1), "ill_decode_w2");
        s(1, 0, 0, BAD, fe(0), "ill_fetch_cnt_clear");
        s(1, 0, 0, BAD, fe(0), "ill_fetch1");
        s(1, 1, 1, BAD, 24'd0, "rst_in_fetch_hold");
        s(1, 0, 0, R, fe(0), "rst_fetch0");
        s(1, 0, 0, R, fe(0), "rst_fetch1");
        s(1, 0, 0, R, fe(1), "rst_fetch2");
        s(1, 0, 0, R, de(0), "rst_decode");
        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle main decoder; a Moore FSM sequences one instruction over 3–5+ cycles.
- Drives the shared-ALU / shared-memory multi-cycle datapath.
- Adds branch, jump, ori and slti support, plus configurable memory wait states, hold (stall) and illegal-opcode detection.

Parameters:
- ALUOP_W, 3, ALUOp width; must be ≥3; upper bits zero-extended.
- MEM_WAIT, 0, extra cycles each memory access state is held (0..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  6  instruction bits [31:26] from the instruction register.
- hold  in  1  stall; freezes the FSM.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write if ALU zero (beq).
- PCWriteCondNe  out  1  PC write if ALU not zero (bne).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read.
- MemWrite  out  1  memory write.
- MemtoReg  out  1  register write-data select: 1=MDR.
- IRWrite  out  1  instruction register load.
- PCSource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=rs.
- ALUSrcB  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- ALUOp  out  ALUOP_W  ALU operation code.
- RegDst  out  1  destination register select: 1=rd.
- RegWrite  out  1  register file write.
- State  out  4  current state, for debug.
- IllegalOp  out  1  unsupported opcode seen in DECODE.

Behaviour:
- ALUOp encoding:
  - 000 add (fetch/address/lw/sw)
  - 001 sub (beq/bne)
  - 010 R-type (funct)
  - 011 addi, 100 andi, 101 ori, 110 slti
- States (encoding):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTEX=6, RTWB=7, IMMEX=8, IMMWB=9, BRANCH=10, JUMP=11
- Transitions:
  - FETCH→DECODE.
  - DECODE by Opcode:
    - 000000→RTEX
    - 100011 / 101011→MEMADR
    - 001000 / 001100 / 001101 / 001010→IMMEX
    - 000100 / 000101→BRANCH
    - 000010→JUMP
    - else→FETCH
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - RTEX→RTWB.
  - IMMEX→IMMWB.
  - MEMWB, MEMWR, RTWB, IMMWB, BRANCH, JUMP→FETCH.
- Opcode latch:
  - Opcode is captured into an internal register on the DECODE cycle.
  - MEMADR, IMMEX and BRANCH decisions use the latched value, so later Opcode changes are ignored.
- Wait states:
  - Applies to FETCH, MEMRD and MEMWR.
  - A 4-bit counter holds the state for MEM_WAIT+1 cycles; the counter clears on exit.
  - MemRead/MemWrite and address selects are asserted on every cycle of the state.
  - IRWrite and PCWrite are asserted only on the final FETCH cycle, so PC advances exactly once.
  - MemWrite is asserted every MEMWR cycle.
- Moore outputs (all others 0):
  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite+PCWrite on the final cycle.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000; IllegalOp=1 if Opcode is unsupported.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000.
  - MEMRD: MemRead, IorD=1.
  - MEMWR: MemWrite, IorD=1.
  - MEMWB: RegWrite, MemtoReg, RegDst=0.
  - RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=010.
  - RTWB: RegWrite, RegDst=1.
  - IMMEX: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode (011/100/101/110).
  - IMMWB: RegWrite, RegDst=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWriteCond for beq, PCWriteCondNe for bne.
  - JUMP: PCWrite, PCSource=10.
- Latency (MEM_WAIT=W):
  - R-type / imm: 4+W.
  - lw: 5+2W.
  - sw: 4+2W.
  - beq / bne / j: 3+W.
  - illegal: 2+W.
- hold:
  - While high, the state, wait counter and latched opcode are frozen.
  - PCWrite, PCWriteCond, PCWriteCondNe, IRWrite, MemWrite and RegWrite are forced 0.
  - Other outputs keep their state values.
- Reset:
  - While rst is high, every output is 0 (State=0), regardless of hold.
  - On the edge, state←FETCH, counter←0, latched opcode←0.
  - Reset mid-instruction abandons it; rst has priority over hold.
  - The first post-reset cycle presents the FETCH outputs.

Test Plan:
- MEM_WAIT=0: rst, then Opcode=000000 → State 0,1,6,7,0; RegWrite=1 and RegDst=1 only in cycle 4; ALUOp=010 in cycle 3.
- MEM_WAIT=2, lw (100011) → FETCH held 3 cycles with IRWrite/PCWrite only on the 3rd; MEMRD held 3 cycles; MEMWB then FETCH; 9 cycles total.
- beq (000100) then bne (000101) → BRANCH has ALUOp=001, PCSource=01, with PCWriteCond=1 for beq and PCWriteCondNe=1 for bne respectively; j (000010) → JUMP has PCWrite=1, PCSource=10.
- Opcode=111111 → IllegalOp=1 for the single DECODE cycle, then FETCH; no RegWrite/MemWrite at any point.
- sw (101011): assert hold for 3 cycles in MEMWR → State stays 5 and MemWrite=0 during hold; after release MemWrite=1 for MEM_WAIT+1 cycles, then FETCH.
- rst pulsed in RTEX with hold=1 → all outputs 0 during rst; FETCH next cycle; addi (001000) then completes with ALUOp=011 in IMMEX.
